gcd_controller: RTL

GCD_CONTROLLER -- requirements
Module: gcd_controller

---
 rtl/gcd_pkg.sv | 20 ++
 rtl/gcd_controller_if.sv | 33 +++
 rtl/gcd_iter_counter.sv | 40 ++++
 rtl/gcd_controller.sv | 125 ++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD controller: FSM state encoding,
// result-select encodings and the default iteration limit.
package gcd_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_A  = 3'd1,
    LOAD_B  = 3'd2,
    COMPARE = 3'd3,
    DONE    = 3'd4
  } gcd_state_e;

  // res_sel values: which datapath register holds the result
  localparam logic RES_A = 1'b0;
  localparam logic RES_B = 1'b1;

  localparam int unsigned ITER_MAX_DEFAULT = 255;
  localparam int unsigned CNT_W            = 8;

endpackage

// File: rtl/gcd_controller_if.sv
// Handshake and strobe bundle between the GCD controller and its datapath.
// master: datapath/requester side; slave: the controller.
interface gcd_controller_if;

  logic start;
  logic op_valid;
  logic op_ready;
  logic lt;
  logic gt;
  logic eq;
  logic a_zero;
  logic b_zero;
  logic lda;
  logic ldb;
  logic sela;
  logic selb;
  logic sel_in;
  logic busy;
  logic done;
  logic res_sel;
  logic err;

  modport master (
    output start, op_valid, lt, gt, eq, a_zero, b_zero,
    input  op_ready, lda, ldb, sela, selb, sel_in, busy, done, res_sel, err
  );

  modport slave (
    input  start, op_valid, lt, gt, eq, a_zero, b_zero,
    output op_ready, lda, ldb, sela, selb, sel_in, busy, done, res_sel, err
  );

endinterface

// File: rtl/gcd_iter_counter.sv
// Subtract-step counter for the GCD timeout (used under GCD_ITER_LIMIT_EN).
// Clear has priority over enable; tc_o is high while the count equals ITER_MAX.
module gcd_iter_counter
  import gcd_pkg::*;
#(
  parameter int unsigned ITER_MAX = ITER_MAX_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(ITER_MAX);

  logic [CNT_W-1:0] count_q, count_d;

  // next count: clear, else increment on a subtract step
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == TC_VAL);

endmodule

// File: rtl/gcd_controller.sv
// GCD subtract-loop controller. Loads A then B from data_in, then each
// COMPARE cycle either finishes or replaces the larger register by the
// difference. Optional timeout enabled by macro GCD_ITER_LIMIT_EN.
module gcd_controller
  import gcd_pkg::*;
#(
  parameter int unsigned ITER_MAX = ITER_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  gcd_controller_if.slave   bus
);

  gcd_state_e state_q, state_d;
  logic       res_sel_q, res_sel_d;
  logic       err_q, err_d;
  logic       lda_c, ldb_c, sel_in_c;
  logic       step_c;
  logic       timeout_c;

`ifdef GCD_ITER_LIMIT_EN
  gcd_iter_counter #(
    .ITER_MAX (ITER_MAX)
  ) u_iter (
    .clk   (clk),
    .rst   (rst),
    .en_i  (step_c),
    .clr_i (state_q == LOAD_A),
    .tc_o  (timeout_c)
  );
`else
  logic unused_cfg;
  assign unused_cfg = (|ITER_MAX) ^ step_c;
  assign timeout_c  = 1'b0;
`endif

  // next state, load strobes and result flags
  always_comb begin
    state_d   = state_q;
    res_sel_d = res_sel_q;
    err_d     = err_q;
    lda_c     = 1'b0;
    ldb_c     = 1'b0;
    sel_in_c  = 1'b0;
    step_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = LOAD_A;
          res_sel_d = RES_A;
          err_d     = 1'b0;
        end
      end
      LOAD_A: begin
        if (bus.op_valid) begin
          lda_c    = 1'b1;
          sel_in_c = 1'b1;
          state_d  = LOAD_B;
        end
      end
      LOAD_B: begin
        if (bus.op_valid) begin
          ldb_c    = 1'b1;
          sel_in_c = 1'b1;
          state_d  = COMPARE;
        end
      end
      COMPARE: begin
        if (bus.a_zero && bus.b_zero) begin
          state_d   = DONE;
          res_sel_d = RES_A;
        end else if (bus.a_zero) begin
          state_d   = DONE;
          res_sel_d = RES_B;
        end else if (bus.b_zero || bus.eq) begin
          state_d   = DONE;
          res_sel_d = RES_A;
        end else if (timeout_c) begin
          state_d   = DONE;
          res_sel_d = RES_A;
          err_d     = 1'b1;
        end else if (bus.gt) begin
          lda_c  = 1'b1;
          step_c = 1'b1;
        end else if (bus.lt) begin
          ldb_c  = 1'b1;
          step_c = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state and held result flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      res_sel_q <= RES_A;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      res_sel_q <= res_sel_d;
      err_q     <= err_d;
    end
  end

  // Outputs are forced low while rst is high, even before the reset edge
  // has returned the FSM to IDLE.
  assign bus.op_ready = ~rst & ((state_q == LOAD_A) || (state_q == LOAD_B));
  assign bus.lda      = ~rst & lda_c;
  assign bus.ldb      = ~rst & ldb_c;
  assign bus.sela     = ~rst & lda_c;
  assign bus.selb     = ~rst & ldb_c;
  assign bus.sel_in   = ~rst & sel_in_c;
  assign bus.busy     = ~rst & (state_q != IDLE);
  assign bus.done     = ~rst & (state_q == DONE);
  assign bus.res_sel  = ~rst & res_sel_q;
  assign bus.err      = ~rst & err_q;

endmodule
